// File: rtl/phase_step_quantizer_if.sv
// phase_step_quantizer_if: phase-in / step-out valid-ready bundle for phase_step_quantizer.
interface phase_step_quantizer_if #(
    parameter int INPUT_WIDTH = 64,
    parameter int SAMPLES = 16
);
    localparam int IDX_W = $clog2(SAMPLES);
    logic in_valid;
    logic in_ready;
    logic signed [INPUT_WIDTH-1:0] in_phase;
    logic out_valid;
    logic out_ready;
    logic [IDX_W-1:0] out_step;
    logic out_err;
    modport master (output in_valid, in_phase, out_ready, input in_ready, out_valid, out_step, out_err);
    modport slave (input in_valid, in_phase, out_ready, output in_ready, out_valid, out_step, out_err);
endinterface

// File: rtl/phase_step_quantizer.sv
// phase_step_quantizer: wraps a signed phase into [0,2pi) and quantises it to a carrier step index.
// Define PHASE_STEP_ROUND_NEAREST_EN for round-to-nearest (SAMPLES wraps to 0) instead of floor with clamp.
module phase_step_quantizer #(
    parameter int INPUT_WIDTH = 64,
    parameter logic signed [INPUT_WIDTH-1:0] M_2_PI = 64'sh00003243f6a8885a,
    parameter int SAMPLES = 16,
    parameter int WRAP_BITS = 4
) (
    input logic clk,
    input logic rst_n,
    phase_step_quantizer_if.slave bus
);
    localparam int IDX_W = $clog2(SAMPLES);
    localparam int W = INPUT_WIDTH + WRAP_BITS + 1;
    localparam int CW = $clog2(WRAP_BITS + IDX_W + 2);
    localparam logic [W-1:0] TWO_PI = W'($unsigned(M_2_PI));
    localparam logic [W-1:0] PHASE_STEP = TWO_PI / W'(SAMPLES);
    localparam logic [W-1:0] LIMIT = TWO_PI << WRAP_BITS;
`ifdef PHASE_STEP_ROUND_NEAREST_EN
    localparam logic [W-1:0] HALF = PHASE_STEP >> 1;
`else
    localparam logic [W-1:0] HALF = '0;
`endif

    typedef enum logic [1:0] {IDLE, REDUCE, DIVIDE, DONE} state_t;
    state_t state, state_nx;
    logic signed [W-1:0] x;
    logic oor;
    logic [W-1:0] r, r_red, sub_r, sub_d;
    logic [IDX_W-1:0] q, step, step_nx;
    logic [IDX_W:0] q_nx;
    logic [CW-1:0] cnt;
    logic err;

    assign x = W'(bus.in_phase);
    assign oor = x >= $signed(LIMIT) || x <= -$signed(LIMIT);
    assign sub_r = TWO_PI << cnt;
    assign sub_d = PHASE_STEP << cnt;
    assign r_red = r >= sub_r ? r - sub_r : r;
    assign q_nx = {q, r >= sub_d};
`ifdef PHASE_STEP_ROUND_NEAREST_EN
    assign step_nx = q_nx == (IDX_W+1)'(SAMPLES) ? '0 : q_nx[IDX_W-1:0];
`else
    assign step_nx = q_nx >= (IDX_W+1)'(SAMPLES) ? IDX_W'(SAMPLES - 1) : q_nx[IDX_W-1:0];
`endif
    assign bus.in_ready = rst_n && state == IDLE;
    assign bus.out_valid = state == DONE;
    assign bus.out_step = step;
    assign bus.out_err = err;

    always_ff @(posedge clk) state <= !rst_n ? IDLE : state_nx;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: state_nx = bus.in_valid ? REDUCE : IDLE;
            REDUCE: state_nx = err ? DONE : (cnt == '0 ? DIVIDE : REDUCE);
            DIVIDE: state_nx = cnt == '0 ? DONE : DIVIDE;
            DONE: state_nx = bus.out_ready ? IDLE : DONE;
            default: state_nx = IDLE;
        endcase
    end

    // Negative inputs are offset by 2pi<<WRAP_BITS so the reduction only ever subtracts.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r <= '0;
            q <= '0;
            cnt <= '0;
            err <= 1'b0;
            step <= '0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    err <= oor;
                    r <= oor ? '0 : (x[W-1] ? x + $signed(LIMIT) : x);
                    cnt <= CW'(WRAP_BITS);
                    q <= '0;
                    step <= '0;
                end
                REDUCE: begin
                    r <= cnt == '0 ? r_red + HALF : r_red;
                    cnt <= cnt == '0 ? CW'(IDX_W) : cnt - 1'b1;
                end
                DIVIDE: begin
                    r <= r >= sub_d ? r - sub_d : r;
                    q <= q_nx[IDX_W-1:0];
                    cnt <= cnt - 1'b1;
                    if (cnt == '0) step <= step_nx;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/phase_step_quantizer.md
Name: phase_step_quantizer

Overview:
- Sequential, parametrised successor to the combinational phase-to-step converter.
- Accepts a signed fixed-point phase in radians (2π = M_2_PI) over a valid/ready handshake and wraps it into [0, 2π), including negative and multi-turn values.
- Quantises the result to a carrier sample-step index 0..SAMPLES-1 with an iterative restoring divider.
- Sits between the phase-tracking/NCO control path and the carrier LUT addressing.

Parameters:
- INPUT_WIDTH, 64, width of signed phase input.
- M_2_PI, 64'sh00003243f6a8885a, 2π in the input fixed-point format.
- SAMPLES, 16, carrier samples per period; must be a power of two, ≥2.
- PHASE_STEP, M_2_PI/SAMPLES, radians per step (truncated).
- WRAP_BITS, 4, accepted input range |x| < M_2_PI·2^WRAP_BITS.
- IDX_W, $clog2(SAMPLES), index width (derived; do not override).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  input phase valid.
- in_ready  out  1  block can accept input.
- in_phase  in  INPUT_WIDTH  signed phase.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_step  out  IDX_W  quantised step index.
- out_err  out  1  input outside accepted range.

Behaviour:
- Reset (rst_n=0 at posedge): state IDLE, in_ready=0 during reset then 1 in IDLE, out_valid=0, out_step=0, out_err=0, internal regs 0. Reset mid-operation aborts silently; no result is emitted.
- States:
  - IDLE: in_ready=1. On in_valid&&in_ready, latch the input and go to REDUCE. Range check at accept: if in_phase ≥ M_2_PI<<WRAP_BITS or in_phase ≤ −(M_2_PI<<WRAP_BITS), set err, load r=0, skip to DONE next edge.
  - REDUCE, WRAP_BITS+1 cycles: negative inputs are first offset at load by +(M_2_PI<<WRAP_BITS). Then for k=WRAP_BITS down to 0, one per cycle: if r ≥ M_2_PI<<k then r −= M_2_PI<<k. Result r ∈ [0, M_2_PI). Exactly 2π reduces to 0.
  - DIVIDE, IDX_W+1 cycles: restoring division q = floor(r/PHASE_STEP), MSB first, one quotient bit per cycle. All compares are unsigned at INPUT_WIDTH+WRAP_BITS+1 bits; no overflow.
  - DONE: q clamped to SAMPLES−1, because PHASE_STEP truncation can give q=SAMPLES. out_step=q, out_valid=1, in_ready=0. Outputs are held stable until out_valid&&out_ready, then return to IDLE. out_valid is never deasserted without a handshake.
- Latency: out_valid rises WRAP_BITS+IDX_W+2 edges after the accepting edge (10 at defaults). An error input takes 1 edge.
- Throughput: one conversion in flight; no new accept is taken in the same cycle as the output handshake. in_ready returns the cycle after.
- out_err is valid only with out_valid. When out_err=1, out_step=0.

Optional Feature:
- PHASE_STEP_ROUND_NEAREST_EN
  - Defined: DIVIDE runs on r+(PHASE_STEP>>1), giving round-to-nearest. A result equal to SAMPLES wraps to 0, not clamps. Latency is unchanged.
  - Undefined: floor with clamp, as above.

Test Plan:
- Reset: hold rst_n=0 for 3 clocks with in_valid=1 -> out_valid=0, out_step=0, out_err=0, nothing accepted; in_ready=1 the first cycle after release.
- in_phase=64'sh00003243f6a8885a (2π) -> out_step=0, out_err=0, after exactly 10 clocks; in_phase=0 -> out_step=0.
- in_phase=64'sh00002de31f8a0903 (5.7359) -> out_step=14 (15 with PHASE_STEP_ROUND_NEAREST_EN); in_phase=64'shffffea1ce075f6fd (−2.7359) -> out_step=9.
- in_phase=64'sh0003243f6a8885a0 (32π) and its negation -> out_err=1, out_step=0, out_valid after 1 clock.
- Backpressure: out_ready=0 for 5 cycles after out_valid -> out_valid/out_step stable and in_ready=0 while held. out_ready=1 -> handshake, next accept on the following cycle; back-to-back stream of 8 random in-range values matches a floor-mod reference model.
- Reset asserted during DIVIDE -> no out_valid emitted; next input converts correctly.
